// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : UART register map, CON bit indices and boot-loader state encoding.
//           Optional feature macro: UART_BOOT_ECHO_EN (adds the echo states).
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_RX_READY_BIT = 3;
  localparam int CON_TX_IDLE_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL      = 3'd1,
    ST_READ      = 3'd2,
`ifdef UART_BOOT_ECHO_EN
    ST_ECHO_WAIT = 3'd3,
    ST_ECHO_WR   = 3'd4,
`endif
    ST_WRITE     = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_assembler
// Brief   : Packs received bytes little-endian into 32-bit words.
// Revision: 1.0 - initial release
// ============================================================================
module uart_word_assembler
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // New bytes enter at the top, so the first byte ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_valid_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= {byte_i, word_q[31:8]};
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_boot_loader
// Brief   : Polls a UART, receives a length-prefixed image and writes it to
//           instruction memory. Optional macro UART_BOOT_ECHO_EN echoes bytes.
// Revision: 1.0 - initial release
// ============================================================================
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] Add,
  output logic        rd,
  output logic        wr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        imem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS_W  = 32'(MAX_WORDS);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  boot_state_e state_q, state_d;
  logic        hdr_q;
  logic [31:0] n_q;
  logic [31:0] k_q;
  logic [31:0] tmo_q;
  logic [31:0] word;
  logic        word_valid;
  logic        capture;
  logic        accept;
  logic        tmo_hit;
  logic        waiting;
  logic        unused_rdata;

  assign capture      = (state_q == ST_READ);
  assign accept       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
  assign tmo_hit      = (tmo_q == TIMEOUT_LAST);
  assign unused_rdata = ^{rdata[31:8], rdata[2:0]};

`ifdef UART_BOOT_ECHO_EN
  logic wc_q;
  assign waiting = (state_q == ST_POLL) || (state_q == ST_ECHO_WAIT);

  // Remembers whether the byte being echoed completed a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wc_q <= 1'b0;
    end else if (capture) begin
      wc_q <= word_valid;
    end
  end
`else
  assign waiting = (state_q == ST_POLL);
`endif

  uart_word_assembler u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (accept),
    .byte_valid_i (capture),
    .byte_i       (rdata[7:0]),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hdr_q   <= 1'b1;
      n_q     <= 32'd0;
      k_q     <= 32'd0;
      tmo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hdr_q <= 1'b1;
        n_q   <= 32'd0;
        k_q   <= 32'd0;
        tmo_q <= 32'd0;
      end else if (capture) begin
        tmo_q <= 32'd0;
      end else if (waiting) begin
        tmo_q <= tmo_q + 32'd1;
      end
      // The header word also passes through WRITE, where it is latched as N.
      if (state_q == ST_WRITE) begin
        if (hdr_q) begin
          hdr_q <= 1'b0;
          n_q   <= word;
        end else begin
          k_q <= k_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_POLL;
      ST_POLL: begin
        if (rdata[CON_RX_READY_BIT]) state_d = ST_READ;
        else if (tmo_hit)            state_d = ST_ERROR;
      end
`ifdef UART_BOOT_ECHO_EN
      ST_READ: state_d = ST_ECHO_WAIT;
      ST_ECHO_WAIT: begin
        if (rdata[CON_TX_IDLE_BIT]) state_d = ST_ECHO_WR;
        else if (tmo_hit)           state_d = ST_ERROR;
      end
      ST_ECHO_WR: state_d = wc_q ? ST_WRITE : ST_POLL;
`else
      ST_READ: state_d = word_valid ? ST_WRITE : ST_POLL;
`endif
      ST_WRITE: begin
        if (hdr_q) begin
          if (word == 32'd0)            state_d = ST_DONE;
          else if (word > MAX_WORDS_W)  state_d = ST_ERROR;
          else                          state_d = ST_POLL;
        end else if (k_q == n_q - 32'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_POLL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd         = 1'b0;
    wr         = 1'b0;
    Add        = 32'd0;
    wdata      = 32'd0;
    imem_we    = 1'b0;
    imem_addr  = 32'd0;
    imem_wdata = 32'd0;
    case (state_q)
      ST_POLL: begin
        rd  = 1'b1;
        Add = UART_CON_ADDR;
      end
      ST_READ: begin
        rd  = 1'b1;
        Add = UART_RXD_ADDR;
      end
`ifdef UART_BOOT_ECHO_EN
      ST_ECHO_WAIT: begin
        rd  = 1'b1;
        Add = UART_CON_ADDR;
      end
      ST_ECHO_WR: begin
        wr    = 1'b1;
        Add   = UART_TXD_ADDR;
        wdata = {24'd0, word[31:24]};
      end
`endif
      ST_WRITE: begin
        if (!hdr_q) begin
          imem_we    = 1'b1;
          imem_addr  = IMEM_BASE + k_q;
          imem_wdata = word;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign cpu_hold = (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_boot_loader
// Brief   : Self-checking bench with a UART model and an image reference model.
//           Echo checks are included when UART_BOOT_ECHO_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;
  import uart_pkg::*;

  localparam int unsigned MAXW    = 256;
  localparam int unsigned TMO     = 100;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          TX_BUSY = 2;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] Add, wdata, rdata, imem_addr, imem_wdata;
  logic        rd, wr, imem_we, cpu_hold, busy, done, error;

  uart_boot_loader #(
    .IMEM_BASE      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .Add        (Add),
    .rd         (rd),
    .wr         (wr),
    .wdata      (wdata),
    .rdata      (rdata),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    int          nwr;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  logic [7:0]  rx_mem[$];
  logic [7:0]  stim[$];
  logic [7:0]  tx_log[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int rx_idx = 0, rx_avail = 0, cyc = 0, tx_idle_at = 0, last_cap = 0;
  int strobe_viol = 0, tx_early = 0;
  bit pop_pend = 1'b0;
  int n_chk = 0, n_pass = 0;

  // UART register model: CON status and RXD data answer combinationally.
  always_comb begin
    rdata = 32'd0;
    if (Add == UART_CON_ADDR) begin
      rdata[CON_RX_READY_BIT] = (rx_idx < rx_mem.size()) && (cyc >= rx_avail);
      rdata[CON_TX_IDLE_BIT]  = (cyc >= tx_idle_at);
    end else if (Add == UART_RXD_ADDR && rx_idx < rx_mem.size()) begin
      rdata[7:0] = rx_mem[rx_idx];
    end
  end

  always @(negedge clk) begin
    pop_pend = rd && (Add == UART_RXD_ADDR);
    if (pop_pend) last_cap = cyc;
    if (imem_we) begin
      log_a.push_back(imem_addr);
      log_d.push_back(imem_wdata);
    end
    if ((int'(rd) + int'(wr) + int'(imem_we)) > 1 || (!rd && !wr && Add != 32'd0) ||
        (!wr && wdata != 32'd0) || (!imem_we && (imem_addr != 32'd0 || imem_wdata != 32'd0)))
      strobe_viol++;
    if (wr && Add == UART_TXD_ADDR) begin
      tx_log.push_back(wdata[7:0]);
      if (cyc <= tx_idle_at) tx_early++;
      tx_idle_at = cyc + 1 + TX_BUSY;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pend) begin
      rx_idx   <= rx_idx + 1;
      rx_avail <= cyc + 1 + int'($urandom_range(0, 4));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_mem.push_back(b);
    stim.push_back(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (done || error) n_pass++;
    else $display("FAIL %s: no done/error after %0d cycles, expected completion", name, n);
  endtask

  // Reference: data word k is bytes 4+4k.. combined least-significant first.
  task automatic check_image(input string name, input int nexp, input bit edone, input bit eerr);
    logic [31:0] w;
    int i;
    check({name, " writes"}, log_a.size(), nexp);
    for (int k = 0; k < nexp && k < log_a.size(); k++) begin
      i = 4 + 4*k;
      w = 32'(stim[i]) | (32'(stim[i+1]) << 8) | (32'(stim[i+2]) << 16) | (32'(stim[i+3]) << 24);
      check($sformatf("%s addr%0d", name, k), log_a[k], BASE + k);
      check($sformatf("%s data%0d", name, k), log_d[k], w);
    end
    check({name, " done"}, done, edone);
    check({name, " error"}, error, eerr);
    check({name, " cpu_hold"}, cpu_hold, !edone);
    check({name, " consumed"}, rx_idx, rx_mem.size());
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_d.delete();
    stim.delete();
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{32'd0,          0,   1'b1, 1'b0};
    vecs[1] = '{32'd1,          1,   1'b1, 1'b0};
    vecs[2] = '{32'd3,          3,   1'b1, 1'b0};
    vecs[3] = '{32'd257,        0,   1'b0, 1'b1};
    vecs[4] = '{32'd256,        256, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000,  0,   1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst cpu_hold", cpu_hold, 1);
    check("rst flags", {busy, done, error}, 0);
    check("rst strobes", {rd, wr, imem_we}, 0);
    check("rst Add", Add, 0);
    check("rst wdata", wdata, 0);
    check("rst imem", imem_addr | imem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    // Two-word image with a start pulse that must be ignored mid-load.
    push_word(32'd2);
    push_byte(8'h78); push_byte(8'h56); push_byte(8'h34); push_byte(8'h12);
    push_byte(8'hEF); push_byte(8'hBE); push_byte(8'hAD); push_byte(8'hDE);
    pulse_start();
    check("load busy", busy, 1);
    check("load cpu_hold", cpu_hold, 1);
    for (int i = 0; i < 500 && log_a.size() == 0; i++) @(negedge clk);
    pulse_start();
    wait_end("img2");
    check_image("img2", 2, 1'b1, 1'b0);
    check("img2 word0", log_d[0], 32'h1234_5678);
    check("img2 word1", log_d[1], 32'hDEAD_BEEF);
    clear_logs();

    for (int v = 0; v < 6; v++) begin
      push_word(vecs[v].hdr);
      for (int k = 0; k < vecs[v].nwr; k++) push_word($urandom);
      pulse_start();
      wait_end($sformatf("vec%0d", v));
      check_image($sformatf("vec%0d", v), vecs[v].nwr, vecs[v].exp_done, vecs[v].exp_err);
      clear_logs();
    end

    // Timeout after a partial header.
    push_byte(8'h05);
    push_byte(8'h00);
    pulse_start();
    wait_end("tmo");
    check("tmo error", error, 1);
    check("tmo cpu_hold", cpu_hold, 1);
`ifdef UART_BOOT_ECHO_EN
    check("tmo latency", cyc - last_cap - 1, TMO + 1);
`else
    check("tmo latency", cyc - last_cap - 1, TMO);
`endif
    check("tmo writes", log_a.size(), 0);
    clear_logs();

    // Reset in the middle of the first data word, then a clean load.
    push_word(32'd3);
    push_byte(8'hAA);
    push_byte(8'hBB);
    pulse_start();
    for (int i = 0; i < 400 && rx_idx != rx_mem.size(); i++) @(negedge clk);
    check("midrst consumed", rx_idx, rx_mem.size());
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midrst strobes", {rd, wr, imem_we}, 0);
    check("midrst flags", {busy, done, error, cpu_hold}, 4'b0001);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst idle", {busy, rd, wr, imem_we}, 0);
    check("midrst writes", log_a.size(), 0);
    clear_logs();
    push_word(32'd3);
    for (int k = 0; k < 3; k++) push_word($urandom);
    pulse_start();
    wait_end("after_rst");
    check_image("after_rst", 3, 1'b1, 1'b0);
    clear_logs();

`ifdef UART_BOOT_ECHO_EN
    tx_log.delete();
    tx_early = 0;
    push_byte(8'h41);
    push_byte(8'h42);
    tx_idle_at = cyc + 5;
    pulse_start();
    wait_end("echo");
    check("echo count", tx_log.size(), 2);
    check("echo byte0", {24'd0, tx_log[0]}, 32'h41);
    check("echo byte1", {24'd0, tx_log[1]}, 32'h42);
    check("echo early", tx_early, 0);
    clear_logs();
`else
    check("no tx writes", tx_log.size(), 0);
`endif

    check("strobe rules", strobe_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter IMEM_BASE, default 32'h0000_0000: word address of the first image word.
REQ-002 SHALL have parameter MAX_WORDS, default 256: largest accepted image length in words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: maximum waiting cycles between received bytes.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle load request.
REQ-007 SHALL have port Add  out  32  peripheral bus address.
REQ-008 SHALL have port rd  out  1  bus read strobe.
REQ-009 SHALL have port wr  out  1  bus write strobe.
REQ-010 SHALL have port wdata  out  32  bus write data.
REQ-011 SHALL have port rdata  in  32  bus read data, valid in the same cycle as rd.
REQ-012 SHALL have port imem_addr  out  32  instruction-memory word address.
REQ-013 SHALL have port imem_wdata  out  32  instruction word.
REQ-014 SHALL have port imem_we  out  1  one-cycle instruction-memory write pulse.
REQ-015 SHALL have port cpu_hold  out  1  holds the CPU in reset while the image is not loaded.
REQ-016 SHALL have ports busy, done and error, each out 1: status flags.

Function
REQ-017 SHALL act as bus initiator to the UART: CON 32'h4000_0020 (bit3 RX byte ready, bit2 TX idle), RXD 32'h4000_001C (read clears ready), TXD 32'h4000_0018.
REQ-018 SHALL implement states IDLE, POLL, READ, ECHO_WAIT, ECHO_WR, WRITE, DONE, ERROR.
REQ-019 SHALL in POLL drive rd=1 with Add=CON each cycle; on rdata[3]=1, go to READ the next cycle.
REQ-020 SHALL in READ drive rd=1 with Add=RXD for exactly one cycle and capture rdata[7:0] at that edge.
REQ-021 SHALL assemble bytes little-endian (first byte = bits 7:0); a 2-bit byte counter wraps 3->0 on word completion.
REQ-022 SHALL treat the first word as header N; N=0 -> DONE directly; N>MAX_WORDS -> ERROR; otherwise receive N data words.
REQ-023 SHALL in WRITE pulse imem_we for one cycle with imem_addr=IMEM_BASE+k (k=0..N-1) and imem_wdata=word, then return to POLL or, after word N-1, enter DONE.
REQ-024 SHALL keep rd, wr and imem_we mutually exclusive and low outside their states; Add, wdata and imem_* SHALL be 0 when unused.
REQ-025 SHALL run a timeout counter in POLL and ECHO_WAIT, cleared on each byte capture; reaching TIMEOUT_CYCLES -> ERROR.
REQ-026 SHALL act on start only in IDLE, DONE or ERROR, clearing done, error, k and counters; start while busy SHALL be ignored.
REQ-027 SHALL assert busy in every state except IDLE, DONE and ERROR; done and error are sticky until the next start.
REQ-028 SHALL drop cpu_hold in the cycle DONE is entered and reassert it on an accepted start.

Reset
REQ-029 SHALL on reset enter IDLE with cpu_hold=1; busy, done, error, rd, wr, imem_we, Add, wdata, imem_addr and imem_wdata=0.
REQ-030 SHALL abort a load in progress on reset mid-operation, with no further bus or memory strobes.

Configuration
REQ-031 SHALL with UART_BOOT_ECHO_EN defined go READ->ECHO_WAIT after each byte, poll CON until bit2=1, then ECHO_WR drives wr=1, Add=TXD, wdata={24'b0,byte} for one cycle.
REQ-032 SHALL without UART_BOOT_ECHO_EN go READ->POLL or WRITE directly; ECHO states absent and wr constantly 0.

Structure
REQ-033 SHALL take the UART register addresses, the CON bit indices and the state enumeration from a shared package uart_pkg.
REQ-034 SHALL contain one sub-module, uart_word_assembler (byte counter, shift register, word-valid pulse).

Verification
REQ-035 SHALL cover: header 2, bytes 78 56 34 12 EF BE AD DE -> imem writes 0x12345678@0 and 0xDEADBEEF@1, then done=1 and cpu_hold=0.
REQ-036 SHALL cover: header 0 -> done=1, no imem_we pulses.
REQ-037 SHALL cover: header 257 with MAX_WORDS=256 -> error=1 and cpu_hold=1.
REQ-038 SHALL cover: TIMEOUT_CYCLES=100, stop after 2 bytes -> error=1 exactly 100 cycles after the last capture.
REQ-039 SHALL cover: reset mid-word, then start and a full image -> correct image from IMEM_BASE with no residual bytes.
REQ-040 SHALL cover, with ECHO_EN: bytes 0x41 0x42 and TX idle delayed by 5 cycles -> TXD writes 0x41 then 0x42, each after bit2=1.
